// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the ROM address/enable and captures the returned
// word with its PC into the IF/ID register, honouring stall, branch and flush.
module fetch_stage #(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic [31:0]       fetch_count_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] RESET_ADDR = {RESET_PC[ADDR_W-1:2], 2'b00};

    state_t              state_reg;
    logic                rom_ce_reg;
    logic [ADDR_W-1:0]   pc_reg;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W-1:0]   id_pc_reg;
    logic [ADDR_W-1:0]   id_pc_next;
    logic [INST_W-1:0]   id_inst_reg;
    logic [INST_W-1:0]   id_inst_next;
    logic [31:0]         fetch_count_reg;
    logic                load_word;

    // Next PC: flush beats stall, stall beats branch, so a branch seen during a
    // stall is simply dropped and must be re-presented by decode.
    always_comb begin
        pc_next = pc_reg;
        if (state_reg == FETCH) begin
            if (flush_i) begin
                pc_next = {new_pc_i[ADDR_W-1:2], 2'b00};
            end else if (stall_if) begin
                pc_next = pc_reg;
            end else if (branch_flag_i) begin
                pc_next = {branch_target_i[ADDR_W-1:2], 2'b00};
            end else begin
                pc_next = pc_reg + PC_STEP;
            end
        end
    end

    // IF/ID register update, independent of the fetch state.
    always_comb begin
        id_pc_next   = id_pc_reg;
        id_inst_next = id_inst_reg;
        load_word    = 1'b0;
        if (flush_i) begin
            id_pc_next   = '0;
            id_inst_next = '0;
        end else if (stall_if && !stall_id) begin
            id_pc_next   = '0;
            id_inst_next = '0;
        end else if (!stall_if && !stall_id) begin
            id_pc_next   = pc_reg;
            id_inst_next = rom_ce_reg ? rom_inst_i : '0;
            load_word    = rom_ce_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            rom_ce_reg      <= 1'b0;
            pc_reg          <= RESET_ADDR;
            id_pc_reg       <= '0;
            id_inst_reg     <= '0;
            fetch_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg  <= FETCH;
                    rom_ce_reg <= 1'b1;
                end
                FETCH: begin
                    state_reg  <= FETCH;
                    rom_ce_reg <= 1'b1;
                end
                default: begin
                    state_reg  <= IDLE;
                    rom_ce_reg <= 1'b0;
                end
            endcase
            pc_reg      <= pc_next;
            id_pc_reg   <= id_pc_next;
            id_inst_reg <= id_inst_next;
            if (load_word) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
        end
    end

    assign rom_ce_o      = rom_ce_reg;
    assign rom_addr_o    = pc_reg;
    assign id_pc_o       = id_pc_reg;
    assign id_inst_o     = id_inst_reg;
    assign fetch_count_o = fetch_count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the ROM model returns each word equal to its address.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [31:0] fetch_count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_inst_i = rom_addr_o;

    fetch_stage #(
        .ADDR_W  (32),
        .INST_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .flush_i        (flush_i),
        .new_pc_i       (new_pc_i),
        .rom_ce_o       (rom_ce_o),
        .rom_addr_o     (rom_addr_o),
        .rom_inst_i     (rom_inst_i),
        .id_pc_o        (id_pc_o),
        .id_inst_o      (id_inst_o),
        .fetch_count_o  (fetch_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full snapshot of the observable outputs after one step.
    task automatic expect_all(input string tag, input logic ce, input logic [31:0] addr,
                              input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] cnt);
        chk({tag, ".ce"}, {31'd0, rom_ce_o}, {31'd0, ce});
        chk({tag, ".addr"}, rom_addr_o, addr);
        chk({tag, ".id_pc"}, id_pc_o, pc);
        chk({tag, ".id_inst"}, id_inst_o, inst);
        chk({tag, ".count"}, fetch_count_o, cnt);
        $display("step %-10s ce=%0b addr=%h id_pc=%h id_inst=%h count=%0d",
                 tag, rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, fetch_count_o);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; branch_flag_i = 1'b0;
        branch_target_i = '0; flush_i = 1'b0; new_pc_i = '0;
        step(); step();
        expect_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);

        // Reset release: rom_ce rises one edge later, then sequential fetch.
        rst = 1'b0;
        step(); expect_all("idle2f", 1'b1, 32'h0, 32'h0, 32'h0, 32'd0);
        step(); expect_all("seq1", 1'b1, 32'h4, 32'h0, 32'h0, 32'd1);
        step(); expect_all("seq2", 1'b1, 32'h8, 32'h4, 32'h4, 32'd2);
        step(); expect_all("seq3", 1'b1, 32'hC, 32'h8, 32'h8, 32'd3);

        // Decode of the branch at 8 redirects; C is the delay slot.
        branch_flag_i = 1'b1; branch_target_i = 32'h0000_0102;
        step(); expect_all("br1", 1'b1, 32'h100, 32'hC, 32'hC, 32'd4);
        branch_flag_i = 1'b0;
        step(); expect_all("br2", 1'b1, 32'h104, 32'h100, 32'h100, 32'd5);

        // Move to pc=10 and stall IF only for two cycles.
        flush_i = 1'b1; new_pc_i = 32'h10;
        step(); expect_all("fl10", 1'b1, 32'h10, 32'h0, 32'h0, 32'd5);
        flush_i = 1'b0; stall_if = 1'b1;
        step(); expect_all("bub1", 1'b1, 32'h10, 32'h0, 32'h0, 32'd5);
        step(); expect_all("bub2", 1'b1, 32'h10, 32'h0, 32'h0, 32'd5);
        stall_if = 1'b0;
        step(); expect_all("bubend", 1'b1, 32'h14, 32'h10, 32'h10, 32'd6);

        // Both stages stalled: everything frozen.
        stall_if = 1'b1; stall_id = 1'b1;
        step(); expect_all("frz1", 1'b1, 32'h14, 32'h10, 32'h10, 32'd6);
        step(); expect_all("frz2", 1'b1, 32'h14, 32'h10, 32'h10, 32'd6);
        step(); expect_all("frz3", 1'b1, 32'h14, 32'h10, 32'h10, 32'd6);
        stall_if = 1'b0; stall_id = 1'b0;
        step(); expect_all("frzend", 1'b1, 32'h18, 32'h14, 32'h14, 32'd7);

        // Flush wins over a simultaneous branch; new PC is word-aligned.
        flush_i = 1'b1; new_pc_i = 32'h0000_4003;
        branch_flag_i = 1'b1; branch_target_i = 32'h0000_0200;
        step(); expect_all("flbr", 1'b1, 32'h4000, 32'h0, 32'h0, 32'd7);
        flush_i = 1'b0; branch_flag_i = 1'b0;
        step(); expect_all("flbr2", 1'b1, 32'h4004, 32'h4000, 32'h4000, 32'd8);

        // Async reset mid-cycle at pc=20.
        flush_i = 1'b1; new_pc_i = 32'h20;
        step(); expect_all("fl20", 1'b1, 32'h20, 32'h0, 32'h0, 32'd8);
        flush_i = 1'b0;
        step(); expect_all("run24", 1'b1, 32'h24, 32'h20, 32'h20, 32'd9);
        #2 rst = 1'b1;
        #1 expect_all("arst", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);
        step(); expect_all("arsthold", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);
        rst = 1'b0;
        step(); expect_all("rel1", 1'b1, 32'h0, 32'h0, 32'h0, 32'd0);
        step(); expect_all("rel2", 1'b1, 32'h4, 32'h0, 32'h0, 32'd1);

        // PC wrap from the top of the address space.
        flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFF;
        step(); expect_all("top", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'd1);
        flush_i = 1'b0;
        step(); expect_all("wrap", 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
